// File: rtl/reg_file_pkg.sv
// Shared widths and write-request record for the 8x32 register file.
// Combinational helper only; no state here.
package reg_file_pkg;

  localparam int REG_W  = 32;
  localparam int REG_N  = 8;
  localparam int ADDR_W = 3;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0]  data;
  } wr_req_t;

  // One-hot storage enable for a staged write; all zero when the stage is empty.
  function automatic logic [REG_N-1:0] decode_en(input wr_req_t req);
    decode_en = '0;
    if (req.valid) decode_en[req.addr] = 1'b1;
  endfunction

endpackage

// File: rtl/reg_file_8x32_if.sv
// Write request, two read ports and status of the 8x32 register file.
// Master drives requests/addresses; slave returns read data and status.
interface reg_file_8x32_if;
  import reg_file_pkg::*;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [REG_W-1:0]  wr_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [REG_W-1:0]  rd_data_a;
  logic [REG_W-1:0]  rd_data_b;
  logic              wr_pending;
  logic [7:0]        wr_count;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b, wr_pending, wr_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b, wr_pending, wr_count
  );

endinterface

// File: rtl/register32_r_en.sv
// 32-bit storage register with load enable; synchronous active-low reset wins over enable.
// Latency: one edge from en to q; no backpressure.
module register32_r_en
  import reg_file_pkg::*;
#(
  parameter logic [REG_W-1:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [REG_W-1:0] d,
  output logic [REG_W-1:0] q
);

  logic [REG_W-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!reset_n)  data_q <= RESET_VALUE;
    else if (en)   data_q <= d;
  end

  assign q = data_q;

endmodule

// File: rtl/reg_file_8x32.sv
// 8x32 register file, two combinational read ports, one write per cycle through a stage register.
// Write commits one edge after it is sampled; no backpressure. REG_FILE_BYPASS_EN forwards the staged write to reads.
module reg_file_8x32
  import reg_file_pkg::*;
#(
  parameter logic [REG_W-1:0] RESET_VALUE = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset_n,
  reg_file_8x32_if.slave bus
);

  wr_req_t          stage_q, stage_d;
  logic [7:0]       wr_count_q, wr_count_d;
  logic [REG_N-1:0] reg_en;
  logic [REG_W-1:0] reg_q [REG_N];
  logic [REG_W-1:0] rd_a, rd_b;

  // Stage reloads every edge, so a new request is captured while the previous one commits.
  always_comb begin
    stage_d       = '0;
    stage_d.valid = bus.wr_en;
    stage_d.addr  = bus.wr_addr;
    stage_d.data  = bus.wr_data;
  end

  always_comb begin
    wr_count_d = wr_count_q;
    if (stage_q.valid) wr_count_d = wr_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stage_q    <= '0;
      wr_count_q <= '0;
    end else begin
      stage_q    <= stage_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign reg_en = decode_en(stage_q);

  for (genvar i = 0; i < REG_N; i++) begin : g_reg
    register32_r_en #(
      .RESET_VALUE(RESET_VALUE)
    ) u_reg (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (reg_en[i]),
      .d       (stage_q.data),
      .q       (reg_q[i])
    );
  end

  always_comb begin
    rd_a = reg_q[bus.rd_addr_a];
    rd_b = reg_q[bus.rd_addr_b];
`ifdef REG_FILE_BYPASS_EN
    if (stage_q.valid && (stage_q.addr == bus.rd_addr_a)) rd_a = stage_q.data;
    if (stage_q.valid && (stage_q.addr == bus.rd_addr_b)) rd_b = stage_q.data;
`else
    // Without forwarding, reads see the old value until the commit edge.
`endif
  end

  assign bus.rd_data_a  = rd_a;
  assign bus.rd_data_b  = rd_b;
  assign bus.wr_pending = stage_q.valid;
  assign bus.wr_count   = wr_count_q;

endmodule

// File: tb/tb_reg_file_8x32.sv
// Randomized and directed stimulus for reg_file_8x32; expected outputs are queued per cycle
// from a reference model and compared by an independent monitor on the falling edge.
module tb_reg_file_8x32;
  import reg_file_pkg::*;

  localparam logic [31:0] RV = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  reg_file_8x32_if bus ();

  reg_file_8x32 #(.RESET_VALUE(RV)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Reference model: array of register values plus a list of accepted but uncommitted writes.
  logic [31:0] m_mem [8];
  logic [2:0]  inf_addr [$];
  logic [31:0] inf_data [$];
  int          m_cnt   = 0;
  bit          m_known = 1'b0;

  // Scoreboard queues, one entry per observed cycle.
  logic [31:0] ea_q [$];
  logic [31:0] eb_q [$];
  logic        ep_q [$];
  logic [7:0]  ec_q [$];
  string       lbl_q [$];

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] exp_rd(input logic [2:0] ra);
`ifdef REG_FILE_BYPASS_EN
    if (inf_addr.size() > 0 && inf_addr[0] == ra) return inf_data[0];
`endif
    return m_mem[ra];
  endfunction

  task automatic model_edge(input logic rst, input logic en, input logic [2:0] addr,
                            input logic [31:0] data);
    if (!rst) begin
      for (int i = 0; i < 8; i++) m_mem[i] = RV;
      inf_addr.delete();
      inf_data.delete();
      m_cnt   = 0;
      m_known = 1'b1;
    end else begin
      if (inf_addr.size() > 0) begin
        m_mem[inf_addr.pop_front()] = inf_data.pop_front();
        m_cnt = (m_cnt + 1) % 256;
      end
      if (en) begin
        inf_addr.push_back(addr);
        inf_data.push_back(data);
      end
    end
  endtask

  task automatic drive(input logic rst, input logic en, input logic [2:0] addr,
                       input logic [31:0] data, input logic [2:0] ra, input logic [2:0] rb,
                       input string lbl);
    reset_n       = rst;
    bus.wr_en     = en;
    bus.wr_addr   = addr;
    bus.wr_data   = data;
    bus.rd_addr_a = ra;
    bus.rd_addr_b = rb;
    if (m_known) begin
      ea_q.push_back(exp_rd(ra));
      eb_q.push_back(exp_rd(rb));
      ep_q.push_back(inf_addr.size() > 0);
      ec_q.push_back(8'(m_cnt));
      lbl_q.push_back(lbl);
    end
    @(posedge clk);
    model_edge(rst, en, addr, data);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (ea_q.size() > 0) begin
        string l;
        l = lbl_q.pop_front();
        chk({l, " rd_data_a"},  bus.rd_data_a,         ea_q.pop_front());
        chk({l, " rd_data_b"},  bus.rd_data_b,         eb_q.pop_front());
        chk({l, " wr_pending"}, {31'd0, bus.wr_pending}, {31'd0, ep_q.pop_front()});
        chk({l, " wr_count"},   {24'd0, bus.wr_count},   {24'd0, ec_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with a write request held active; the request must be ignored.
    drive(1'b0, 1'b1, 3'd3, 32'hDEAD_BEEF, 3'd3, 3'd3, "reset");
    drive(1'b0, 1'b1, 3'd3, 32'hDEAD_BEEF, 3'd3, 3'd3, "reset");
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 3'd0, 32'd0, 3'(i), 3'(7 - i), "reset_rd");

    // Single write: pending after sampling, visible after commit.
    drive(1'b1, 1'b1, 3'd5, 32'h1111_1010, 3'd5, 3'd5, "single_wr");
    drive(1'b1, 1'b0, 3'd0, 32'd0, 3'd5, 3'd5, "single_pend");
    drive(1'b1, 1'b0, 3'd0, 32'd0, 3'd5, 3'd0, "single_commit");

    // Back-to-back writes to every address from a clean state.
    drive(1'b0, 1'b0, 3'd0, 32'd0, 3'd0, 3'd0, "b2b_rst");
    for (int i = 0; i < 8; i++)
      drive(1'b1, 1'b1, 3'(i), 32'h1000_0000 + i, 3'(i), 3'(7 - i), "b2b_wr");
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 3'd0, 32'd0, 3'(i), 3'(7 - i), "b2b_rd");

    // Same-address burst: later write wins.
    drive(1'b1, 1'b1, 3'd2, 32'h1100_0011, 3'd2, 3'd2, "same_addr");
    drive(1'b1, 1'b1, 3'd2, 32'h1010_0101, 3'd2, 3'd2, "same_addr");
    drive(1'b1, 1'b0, 3'd0, 32'd0, 3'd2, 3'd2, "same_addr");
    drive(1'b1, 1'b0, 3'd0, 32'd0, 3'd2, 3'd2, "same_addr_final");

    // Reset arriving while a write is staged discards it.
    drive(1'b1, 1'b1, 3'd4, 32'h1110_0111, 3'd4, 3'd4, "mid_rst_wr");
    drive(1'b0, 1'b0, 3'd0, 32'd0, 3'd4, 3'd4, "mid_rst");
    drive(1'b1, 1'b0, 3'd0, 32'd0, 3'd4, 3'd4, "mid_rst_chk");
    drive(1'b1, 1'b0, 3'd0, 32'd0, 3'd4, 3'd4, "mid_rst_chk");

    // Read of the staged address during the pending cycle.
    drive(1'b1, 1'b1, 3'd6, 32'hCAFE_0006, 3'd6, 3'd6, "fwd_old");
    drive(1'b1, 1'b0, 3'd0, 32'd0, 3'd6, 3'd6, "fwd_old");
    drive(1'b1, 1'b1, 3'd6, 32'h0000_0101, 3'd0, 3'd6, "fwd_wr");
    drive(1'b1, 1'b0, 3'd0, 32'd0, 3'd1, 3'd6, "fwd_pend");
    drive(1'b1, 1'b0, 3'd0, 32'd0, 3'd6, 3'd6, "fwd_done");

    // Sustained writes long enough to wrap the commit counter.
    drive(1'b0, 1'b0, 3'd0, 32'd0, 3'd0, 3'd0, "wrap_rst");
    for (int i = 0; i < 300; i++)
      drive(1'b1, 1'b1, 3'($urandom_range(7)), $urandom, 3'($urandom_range(7)),
            3'($urandom_range(7)), "wrap");

    // Mixed random traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      drive(($urandom_range(31) != 0), 1'($urandom_range(1)), 3'($urandom_range(7)), $urandom,
            3'($urandom_range(7)), 3'($urandom_range(7)), "random");

    drive(1'b1, 1'b0, 3'd0, 32'd0, 3'd0, 3'd7, "drain");
    drive(1'b1, 1'b0, 3'd0, 32'd0, 3'd3, 3'd4, "drain");

    for (int i = 0; i < 10 && ea_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (ea_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", ea_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_8x32.md
REG_FILE_8X32 -- requirements
Module: reg_file_8x32

Interface
REQ-001 Parameter RESET_VALUE, default 32'h0000_0000, value loaded into every storage register on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, synchronous and active-low.
REQ-004 wr_en  input  1  write request, sampled each rising edge.
REQ-005 wr_addr  input  3  destination register index 0-7.
REQ-006 wr_data  input  32  write data.
REQ-007 rd_addr_a  input  3  read port A index.
REQ-008 rd_addr_b  input  3  read port B index.
REQ-009 rd_data_a  output  32  read port A data, combinational from state.
REQ-010 rd_data_b  output  32  read port B data, combinational from state.
REQ-011 wr_pending  output  1  write-stage register holds an uncommitted write.
REQ-012 wr_count  output  8  number of committed writes, modulo 256.

Function
REQ-013 Two-stage write path SHALL apply: edge N samples wr_en/wr_addr/wr_data into the write stage; edge N+1 commits the stage into reg[stage_addr].
REQ-014 wr_pending SHALL equal the write-stage valid bit, i.e. 1 in the cycle after an edge that sampled wr_en=1.
REQ-015 The write stage SHALL reload every edge: when wr_en=1 it captures the new request while the previous one commits, sustaining one write per cycle.
REQ-016 When wr_en=0 at an edge, the stage valid SHALL clear and no register changes at the following edge beyond the commit of the prior stage contents.
REQ-017 Consecutive writes to the same address SHALL commit in order; the later write is the final value.
REQ-018 Decoder SHALL assert exactly one storage enable when stage valid=1 and none otherwise.
REQ-019 Reads SHALL be combinational: rd_data_x = reg[rd_addr_x]; both ports may read the same address.
REQ-020 wr_count SHALL increment by 1 on every edge that commits a write, wrapping 255 -> 0.
REQ-021 Without bypass, a read of the address being written returns the old value until the commit edge has passed.

Reset
REQ-022 At a rising edge with reset_n=0: all eight registers = RESET_VALUE, stage valid = 0, wr_pending = 0, wr_count = 0.
REQ-023 Reset SHALL take priority over commit: a write pending at the reset edge is discarded and never committed.
REQ-024 Requests with wr_en=1 at a reset edge SHALL be ignored.

Configuration
REQ-025 Macro REG_FILE_BYPASS_EN defined: when wr_pending=1 and rd_addr_x equals the stage address, rd_data_x SHALL return the stage data (read-after-write forwarding), independently per port.
REQ-026 Macro REG_FILE_BYPASS_EN undefined: no forwarding; REQ-021 applies; port list unchanged.

Structure
REQ-027 Shared package reg_file_pkg SHALL hold: REG_W = 32, REG_N = 8, ADDR_W = 3, the write-request typedef (valid, addr, data).
REQ-028 Storage SHALL be eight instances of register32_r_en (clk, reset_n, en, d, q), whose reset is synchronous active-low, each en driven by the decoder.
REQ-029 The decoder, write stage, read muxes and counter SHALL live in reg_file_8x32; no further sub-modules.

Verification
REQ-030 Reset: reset_n=0 for 2 edges with wr_en=1, wr_addr=3, wr_data=32'hDEAD_BEEF -> all reads 0, wr_pending=0, wr_count=0.
REQ-031 Single write: wr_en=1, wr_addr=5, wr_data=32'h1111_1010 at edge N -> wr_pending=1 after N; rd_addr_a=5 reads 32'h1111_1010 after N+1; wr_count=1.
REQ-032 Back-to-back writes to addresses 0..7 with data 32'h1000_0000+i over 8 edges -> every register holds its value, wr_count=8, both ports verified on all addresses.
REQ-033 Same-address burst: addr 2 written 32'h1100_0011 then 32'h1010_0101 on consecutive edges -> final reg[2]=32'h1010_0101.
REQ-034 Reset mid-op: write 32'h1110_0111 to addr 4 at edge N, reset_n=0 at edge N+1 -> reg[4]=RESET_VALUE, wr_count=0.
REQ-035 Forwarding: write 32'h0000_0101 to addr 6 with rd_addr_b=6 in the pending cycle -> reads 32'h0000_0101 with REG_FILE_BYPASS_EN, old value without.
